// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding and default streak limit for the memory arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } state_t;
  localparam int STREAK_MAX_DEF = 2;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, data first with bounded fetch starvation.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wmask,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall,
  output logic                err
);
  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STREAK_MAX);
  state_t state, state_n;
  logic [SW-1:0] streak;
  logic idle, pick_i, acc;
  always_comb begin
    idle      = state == IDLE;
    pick_i    = i_req & (~d_req | streak == SMAX);
    mem_valid = ~rst & idle & (i_req | d_req);
    mem_we    = ~pick_i & d_we;
    mem_wmask = d_wmask;
    mem_addr  = pick_i ? i_addr : d_addr;
    mem_wdata = d_wdata;
    acc       = mem_valid & mem_ready;
    i_rvalid  = ~rst & state == I_WAIT & mem_rvalid;
    d_done    = ~rst & ((state == D_WAIT & mem_rvalid) | (acc & ~pick_i & d_we));
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
    stall     = (i_req & ~i_rvalid) | (d_req & ~d_done);
    state_n   = acc ? (pick_i ? I_WAIT : d_we ? IDLE : D_WAIT)
              : (~idle & mem_rvalid) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      streak <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_n;
      // a fetch grant and an idle fetch line both restart the starvation count
      if (~i_req | (acc & pick_i)) streak <= '0;
      else if (acc && streak != SMAX) streak <= streak + 1'b1;
      if ((idle & mem_rvalid) | (state == I_WAIT & ~i_req) | (state == D_WAIT & ~d_req))
        err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors with hand-computed expectations for mem_arbiter.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst, i_req, i_rvalid, d_req, d_we, d_done, mem_valid, mem_ready, mem_we, mem_rvalid, stall, err;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  d_wmask, mem_wmask;
  int pass_cnt = 0, total = 0;
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall(stall), .err(err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic clear;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_wmask = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask
  task automatic step;
    @(negedge clk);
  endtask
  logic exp_i [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  initial begin
    clear;
    rst = 1; i_req = 1; d_req = 1; mem_ready = 1; mem_rvalid = 1;
    step; #1;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_i_rvalid", i_rvalid, 0);
    check("rst_d_done", d_done, 0);
    check("rst_stall", stall, 1);
    step;
    check("rst_err", err, 0);
    check("rst_state", dut.state, 0);
    rst = 0; clear;
    step;
    i_req = 1; i_addr = 32'h100; mem_ready = 1; #1;
    check("f_valid", mem_valid, 1);
    check("f_addr", mem_addr, 32'h100);
    check("f_we", mem_we, 0);
    check("f_stall", stall, 1);
    for (int k = 0; k < 2; k++) begin
      step; #1;
      check("f_wait_valid", mem_valid, 0);
      check("f_wait_rvalid", i_rvalid, 0);
      check("f_wait_stall", stall, 1);
    end
    step; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; #1;
    check("f_rvalid", i_rvalid, 1);
    check("f_rdata", i_rdata, 32'hDEADBEEF);
    check("f_stall_end", stall, 0);
    step; clear; #1;
    check("f_rvalid_once", i_rvalid, 0);
    check("f_back_idle", dut.state, 0);
    check("f_err", err, 0);
    i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h200; mem_ready = 1; #1;
    check("fl_load_first", mem_addr, 32'h200);
    check("fl_load_we", mem_we, 0);
    step; #1;
    check("fl_dwait", dut.state, 2);
    mem_rvalid = 1; mem_rdata = 32'h11111111; #1;
    check("fl_d_done", d_done, 1);
    check("fl_d_rdata", d_rdata, 32'h11111111);
    check("fl_no_irv", i_rvalid, 0);
    check("fl_stall_i", stall, 1);
    step; d_req = 0; mem_rvalid = 0; #1;
    check("fl_fetch_valid", mem_valid, 1);
    check("fl_fetch_addr", mem_addr, 32'h100);
    step; mem_rvalid = 1; mem_rdata = 32'h22222222; #1;
    check("fl_i_rvalid", i_rvalid, 1);
    check("fl_i_rdata", i_rdata, 32'h22222222);
    step; clear;
    step;
    i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h200; mem_ready = 1;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 0;
      if (k == 3) i_req = 0;
      #1;
      check($sformatf("st_grant%0d", k), mem_addr, exp_i[k] ? 32'h100 : 32'h200);
      check($sformatf("st_valid%0d", k), mem_valid, 1);
      step; mem_rvalid = 1; mem_rdata = 32'h30 + k; #1;
      check($sformatf("st_resp%0d", k), exp_i[k] ? i_rvalid : d_done, 1);
      step;
    end
    clear;
    step;
    d_req = 1; d_we = 1; d_wmask = 4'b0011; d_addr = 32'h40; d_wdata = 32'hCAFEF00D;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("s_valid", mem_valid, 1);
      check("s_no_done", d_done, 0);
      check("s_wmask", mem_wmask, 4'b0011);
      check("s_we", mem_we, 1);
      check("s_wdata", mem_wdata, 32'hCAFEF00D);
      step;
      check("s_idle", dut.state, 0);
    end
    mem_ready = 1; #1;
    check("s_done", d_done, 1);
    check("s_stall", stall, 0);
    step;
    check("s_idle_after", dut.state, 0);
    clear;
    step;
    d_req = 1; d_addr = 32'h80; mem_ready = 1;
    step;
    check("r_dwait", dut.state, 2);
    rst = 1; #1;
    check("r_no_valid", mem_valid, 0);
    step; rst = 0; clear; mem_rvalid = 1; #1;
    check("r_idle", dut.state, 0);
    check("r_no_done", d_done, 0);
    step; mem_rvalid = 0; #1;
    check("r_err", err, 1);
    for (int k = 0; k < 3; k++) begin
      step;
      check("r_err_sticky", err, 1);
    end
    rst = 1; step; rst = 0; #1;
    check("r_err_clear", err, 0);
    mem_rvalid = 1; step; mem_rvalid = 0; #1;
    check("idle_rv_err", err, 1);
    rst = 1; step; rst = 0;
    i_req = 1; i_addr = 32'h104; mem_ready = 1;
    step; i_req = 0; mem_rvalid = 1; mem_rdata = 32'h55; #1;
    check("drop_consumed", i_rvalid, 1);
    step; mem_rvalid = 0; #1;
    check("drop_err", err, 1);
    check("drop_idle", dut.state, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; wmask width is DATA_W/8.
REQ-003 SHALL have parameter STREAK_MAX, default 2, the maximum number of consecutive data grants while a fetch waits.
REQ-004 SHALL have ports:
 - clk  in  1  sole clock; all state on rising edge.
 - rst  in  1  synchronous, active-high reset.
 - i_req  in  1  fetch request; held with i_addr until i_rvalid.
 - i_addr  in  ADDR_W  fetch address.
 - i_rvalid  out  1  fetch data valid, one cycle.
 - i_rdata  out  DATA_W  fetch data.
 - d_req  in  1  load/store request; held with d_* until done.
 - d_we  in  1  1 = store.
 - d_wmask  in  DATA_W/8  byte enables for a store.
 - d_addr  in  ADDR_W  data address.
 - d_wdata  in  DATA_W  store data.
 - d_done  out  1  one-cycle pulse: load data valid, or store accepted.
 - d_rdata  out  DATA_W  load data.
 - mem_valid  out  1  request to the shared memory port.
 - mem_ready  in  1  memory accepts the request when mem_valid is also high.
 - mem_we, mem_wmask, mem_addr, mem_wdata  out  1, DATA_W/8, ADDR_W, DATA_W  request fields.
 - mem_rvalid  in  1  read response valid.
 - mem_rdata  in  DATA_W  read response data.
 - stall  out  1  freezes the pipeline.
 - err  out  1  sticky protocol error flag.

Function
REQ-005 SHALL implement states IDLE, I_WAIT and D_WAIT, with at most one outstanding memory read.
REQ-006 In IDLE, SHALL drive mem_valid = i_req | d_req; mem_* fields come from the winner, combinationally.
REQ-007 Winner SHALL be data when d_req is high, except that fetch wins when i_req is high and streak == STREAK_MAX.
REQ-008 Streak counter SHALL increment on each accepted data request while i_req is high, saturating at STREAK_MAX.
REQ-009 Streak counter SHALL clear on an accepted fetch and whenever i_req is low.
REQ-010 Acceptance is mem_valid & mem_ready in IDLE; without acceptance SHALL remain in IDLE and re-arbitrate next cycle.
REQ-011 Accepted fetch SHALL move to I_WAIT.
REQ-012 Accepted load SHALL move to D_WAIT.
REQ-013 Accepted store SHALL pulse d_done in the same cycle and stay in IDLE; no response is expected.
REQ-014 In I_WAIT/D_WAIT, SHALL hold mem_valid low.
REQ-015 On mem_rvalid in I_WAIT or D_WAIT, SHALL return to IDLE the next cycle; the next grant occurs in that IDLE cycle, so the minimum back-to-back read spacing is 2 cycles.
REQ-016 On mem_rvalid in I_WAIT, SHALL assert i_rvalid with i_rdata = mem_rdata in the same cycle; zero added latency.
REQ-017 On mem_rvalid in D_WAIT, SHALL assert d_done with d_rdata = mem_rdata in the same cycle.
REQ-018 i_rdata and d_rdata SHALL be don't-care when their valid is low.
REQ-019 stall SHALL equal (i_req & ~i_rvalid) | (d_req & ~d_done).
REQ-020 mem_rvalid in IDLE SHALL set err and be otherwise ignored.
REQ-021 mem_ready SHALL be ignored outside IDLE.
REQ-022 A requester dropping its req while its own access is outstanding SHALL set err; the response is still consumed and the state still returns to IDLE.
REQ-023 With simultaneous i_req and d_req in IDLE and mem_ready high, exactly one grant SHALL occur.

Reset
REQ-024 On rst, SHALL return to IDLE, clear streak and clear err; any outstanding access is abandoned.
REQ-025 During rst, SHALL hold i_rvalid, d_done and mem_valid low; stall follows REQ-019 with the valids low.
REQ-026 rst SHALL dominate all other inputs in the same cycle.

Structure
REQ-027 SHALL place the state encoding (IDLE = 0, I_WAIT = 1, D_WAIT = 2) and the default STREAK_MAX in the shared hardware header package.
REQ-028 No sub-module is required; the block is one FSM plus a 2-bit streak counter.

Verification
REQ-029 Fetch 0x100, mem_ready = 1, response after 3 cycles with 0xDEADBEEF -> i_rvalid exactly 1 cycle, i_rdata = 0xDEADBEEF, stall high until then.
REQ-030 Fetch and load of 0x200 together -> load granted first; fetch granted in the IDLE cycle after the load response.
REQ-031 d_req held with 3 back-to-back loads while i_req is high, STREAK_MAX = 2 -> grant order D, D, I, D.
REQ-032 Store with d_wmask = 4'b0011 to 0x40 and mem_ready low 2 cycles -> d_done pulses only in the cycle mem_ready rises; mem_wmask = 0011; state never leaves IDLE.
REQ-033 rst asserted in D_WAIT, then a stray mem_rvalid -> state IDLE, err = 1, no d_done.
REQ-034 mem_rvalid in IDLE -> err = 1 and stays 1 until rst.
